// File: rtl/bus_fetch_unit.sv
// Bus controller: instruction prefetch into the queue plus EU data reads/writes,
// EU has priority; misaligned EU words are split into two byte-lane bus cycles.
module bus_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cs,
    input  logic [15:0] pfp,
    input  logic        queue_full,
    input  logic        flush,
    output logic        push,
    output logic [15:0] push_data,
    input  logic        eu_req,
    input  logic        eu_we,
    input  logic        eu_wide,
    input  logic [19:0] eu_addr,
    input  logic [15:0] eu_wdata,
    output logic        eu_ack,
    output logic [15:0] eu_rdata,
    output logic [19:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] EU1   = 3'd2;
    localparam logic [2:0] EU2   = 3'd3;
    localparam logic [2:0] ACK   = 3'd4;

    logic [2:0]  state;
    logic        discard;
    logic        odd_pfp;
    logic        eu_we_q;
    logic        eu_wide_q;
    logic [19:0] eu_addr_q;
    logic [7:0]  eu_whi_q;
    logic [7:0]  lo_byte;
    logic [19:0] pa;
    logic [19:0] addr_next;

    assign pa        = {cs, 4'b0} + {4'b0, pfp};
    assign addr_next = eu_addr_q + 20'd1;
    assign busy      = (state == FETCH) || (state == EU1) || (state == EU2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            discard   <= 1'b0;
            odd_pfp   <= 1'b0;
            eu_we_q   <= 1'b0;
            eu_wide_q <= 1'b0;
            eu_addr_q <= '0;
            eu_whi_q  <= '0;
            lo_byte   <= '0;
            push      <= 1'b0;
            push_data <= '0;
            eu_ack    <= 1'b0;
            eu_rdata  <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            push   <= 1'b0;
            eu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (eu_req) begin
                        state     <= EU1;
                        eu_we_q   <= eu_we;
                        eu_wide_q <= eu_wide;
                        eu_addr_q <= eu_addr;
                        eu_whi_q  <= eu_wdata[15:8];
                        mem_rd    <= !eu_we;
                        mem_wr    <= eu_we;
                        mem_addr  <= eu_addr & 20'hFFFFE;
                        if (eu_wide && !eu_addr[0]) begin
                            mem_be    <= 2'b11;
                            mem_wdata <= eu_wdata;
                        end else begin
                            // byte access, or the first (high-lane) half of a split word
                            mem_be    <= eu_addr[0] ? 2'b10 : 2'b01;
                            mem_wdata <= {2{eu_wdata[7:0]}};
                        end
                    end else if (!queue_full && !flush) begin
                        state    <= FETCH;
                        odd_pfp  <= pfp[0];
                        mem_rd   <= 1'b1;
                        mem_wr   <= 1'b0;
                        mem_addr <= pa & 20'hFFFFE;
                        mem_be   <= pfp[0] ? 2'b10 : 2'b11;
                    end
                end
                FETCH: begin
                    if (flush)
                        discard <= 1'b1;
                    if (mem_ready) begin
                        state  <= ACK;
                        mem_rd <= 1'b0;
                        // a flush in the completing cycle must also suppress the push
                        if (!(discard || flush)) begin
                            push      <= 1'b1;
                            push_data <= odd_pfp ? {8'h00, mem_rdata[15:8]} : mem_rdata;
                        end
                    end
                end
                EU1: begin
                    if (mem_ready) begin
                        if (eu_wide_q && eu_addr_q[0]) begin
                            state     <= EU2;
                            lo_byte   <= mem_rdata[15:8];
                            mem_addr  <= addr_next & 20'hFFFFE;
                            mem_be    <= 2'b01;
                            mem_wdata <= {2{eu_whi_q}};
                        end else begin
                            state  <= ACK;
                            mem_rd <= 1'b0;
                            mem_wr <= 1'b0;
                            eu_ack <= 1'b1;
                            if (!eu_we_q)
                                eu_rdata <= eu_wide_q ? mem_rdata :
                                            {8'h00, eu_addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0]};
                        end
                    end
                end
                EU2: begin
                    if (mem_ready) begin
                        state  <= ACK;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        eu_ack <= 1'b1;
                        if (!eu_we_q)
                            eu_rdata <= {mem_rdata[7:0], lo_byte};
                    end
                end
                ACK: begin
                    state   <= IDLE;
                    discard <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_fetch_unit.sv
// Self-checking bench for bus_fetch_unit: vector tables for prefetch and EU
// accesses plus hand sequences for flush, full queue and reset corners.
module tb_bus_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cs, pfp;
    logic        queue_full, flush;
    logic        push;
    logic [15:0] push_data;
    logic        eu_req, eu_we, eu_wide;
    logic [19:0] eu_addr;
    logic [15:0] eu_wdata;
    logic        eu_ack;
    logic [15:0] eu_rdata;
    logic [19:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_push[$];
    logic [16:0] exp_eu[$];   // {is_read, rdata}

    always #5 clk = ~clk;

    bus_fetch_unit dut (
        .clk(clk), .reset(reset), .cs(cs), .pfp(pfp), .queue_full(queue_full),
        .flush(flush), .push(push), .push_data(push_data), .eu_req(eu_req),
        .eu_we(eu_we), .eu_wide(eu_wide), .eu_addr(eu_addr), .eu_wdata(eu_wdata),
        .eu_ack(eu_ack), .eu_rdata(eu_rdata), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    typedef struct {
        logic [15:0] cs, pfp, rd;
        int          waits;
        logic [19:0] ea;
        logic [1:0]  eb;
        logic [15:0] ed;
    } fvec_t;

    typedef struct {
        logic        we, wide;
        logic [19:0] addr;
        logic [15:0] wd, rd1, rd2;
        int          waits;
        logic [19:0] ea1;
        logic [1:0]  eb1;
        logic [15:0] ewd1;
        logic        split;
        logic [19:0] ea2;
        logic [1:0]  eb2;
        logic [15:0] ewd2, erd;
    } evec_t;

    fvec_t fv[5];
    evec_t ev[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_push"}, push, 0);
        chk({nm, "_push_data"}, push_data, 0);
        chk({nm, "_eu_ack"}, eu_ack, 0);
        chk({nm, "_eu_rdata"}, eu_rdata, 0);
        chk({nm, "_mem_addr"}, mem_addr, 0);
        chk({nm, "_mem_rd"}, mem_rd, 0);
        chk({nm, "_mem_wr"}, mem_wr, 0);
        chk({nm, "_mem_be"}, mem_be, 0);
        chk({nm, "_mem_wdata"}, mem_wdata, 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    // Called in the first strobe cycle; holds mem_ready low for 'waits' cycles.
    task automatic bus_cycle(input int waits, input logic [15:0] rd, input logic [19:0] ea,
                             input logic [1:0] eb, input logic erd, input logic ewr,
                             input logic [15:0] ewd, input string nm);
        mem_ready = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            chk({nm, "_rd"}, mem_rd, erd);
            chk({nm, "_wr"}, mem_wr, ewr);
            chk({nm, "_addr"}, mem_addr, ea);
            chk({nm, "_be"}, mem_be, eb);
            chk({nm, "_busy"}, busy, 1);
            if (ewr) chk({nm, "_wdata"}, mem_wdata, ewd);
            if (i == waits) begin
                mem_ready = 1'b1;
                mem_rdata = rd;
            end
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic run_fetch(input fvec_t v);
        cs = v.cs;
        pfp = v.pfp;
        queue_full = 1'b0;
        exp_push.push_back(v.ed);
        tick();
        queue_full = 1'b1;
        bus_cycle(v.waits, v.rd, v.ea, v.eb, 1'b1, 1'b0, 16'h0, "fetch");
        chk("push_timing", push, 1);
        chk("ack_busy", busy, 0);
        tick();
        chk("push_pulse", push, 0);
    endtask

    task automatic run_eu(input evec_t v);
        eu_req = 1'b1;
        eu_we = v.we;
        eu_wide = v.wide;
        eu_addr = v.addr;
        eu_wdata = v.wd;
        queue_full = 1'b0;
        exp_eu.push_back({!v.we, v.erd});
        tick();
        bus_cycle(v.waits, v.rd1, v.ea1, v.eb1, !v.we, v.we, v.ewd1, "eu1");
        if (v.split)
            bus_cycle(0, v.rd2, v.ea2, v.eb2, !v.we, v.we, v.ewd2, "eu2");
        chk("eu_ack_timing", eu_ack, 1);
        chk("eu_no_push", push, 0);
        eu_req = 1'b0;
        queue_full = 1'b1;
        tick();
        chk("eu_ack_pulse", eu_ack, 0);
    endtask

    // Scoreboard: every push / eu_ack must match the oldest expectation.
    always @(posedge clk) begin
        logic [15:0] ep;
        logic [16:0] ee;
        #1;
        if (push === 1'b1) begin
            if (exp_push.size() == 0) chk("push_unexpected", push, 0);
            else begin
                ep = exp_push.pop_front();
                chk("push_data", push_data, ep);
            end
        end
        if (eu_ack === 1'b1) begin
            if (exp_eu.size() == 0) chk("eu_ack_unexpected", eu_ack, 0);
            else begin
                ee = exp_eu.pop_front();
                if (ee[16]) chk("eu_rdata", eu_rdata, ee[15:0]);
            end
        end
    end

    initial begin
        fvec_t tmp;
        fv[0] = '{16'h1000, 16'h0004, 16'hBEEF, 0, 20'h10004, 2'b11, 16'hBEEF};
        fv[1] = '{16'hFFFF, 16'h0017, 16'h12AB, 0, 20'h00006, 2'b10, 16'h0012};
        fv[2] = '{16'h0000, 16'hFFFE, 16'h5566, 2, 20'h0FFFE, 2'b11, 16'h5566};
        fv[3] = '{16'h1234, 16'h0101, 16'hCAFE, 1, 20'h12440, 2'b10, 16'h00CA};
        fv[4] = '{16'hF000, 16'hFFFF, 16'h7788, 0, 20'hFFFFE, 2'b10, 16'h0077};

        ev[0] = '{1'b1, 1'b1, 20'h20001, 16'hA1B2, 16'h0000, 16'h0000, 0,
                  20'h20000, 2'b10, 16'hB2B2, 1'b1, 20'h20002, 2'b01, 16'hA1A1, 16'h0000};
        ev[1] = '{1'b0, 1'b1, 20'h30003, 16'h0000, 16'h5500, 16'h0066, 1,
                  20'h30002, 2'b10, 16'h0000, 1'b1, 20'h30004, 2'b01, 16'h0000, 16'h6655};
        ev[2] = '{1'b0, 1'b0, 20'h40001, 16'h0000, 16'h9A12, 16'h0000, 0,
                  20'h40000, 2'b10, 16'h0000, 1'b0, 20'h0, 2'b00, 16'h0000, 16'h009A};
        ev[3] = '{1'b0, 1'b1, 20'h40002, 16'h0000, 16'h1357, 16'h0000, 1,
                  20'h40002, 2'b11, 16'h0000, 1'b0, 20'h0, 2'b00, 16'h0000, 16'h1357};
        ev[4] = '{1'b1, 1'b0, 20'h50000, 16'h77C3, 16'h0000, 16'h0000, 2,
                  20'h50000, 2'b01, 16'hC3C3, 1'b0, 20'h0, 2'b00, 16'h0000, 16'h0000};
        ev[5] = '{1'b1, 1'b1, 20'h50002, 16'h1234, 16'h0000, 16'h0000, 0,
                  20'h50002, 2'b11, 16'h1234, 1'b0, 20'h0, 2'b00, 16'h0000, 16'h0000};
        ev[6] = '{1'b0, 1'b0, 20'h50004, 16'h0000, 16'h9A12, 16'h0000, 0,
                  20'h50004, 2'b01, 16'h0000, 1'b0, 20'h0, 2'b00, 16'h0000, 16'h0012};

        reset = 1'b1; cs = '0; pfp = '0; queue_full = 1'b1; flush = 1'b0;
        eu_req = 1'b0; eu_we = 1'b0; eu_wide = 1'b0; eu_addr = '0; eu_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        foreach (fv[i]) run_fetch(fv[i]);

        // Full queue blocks prefetch; dropping it starts a fetch on the next edge.
        for (int i = 0; i < 20; i++) begin
            chk("full_no_rd", mem_rd, 0);
            tick();
        end
        run_fetch(fv[0]);

        // Flush while a 3-wait fetch is outstanding.
        cs = 16'h0000; pfp = 16'h0010; queue_full = 1'b0;
        tick();
        queue_full = 1'b1;
        chk("flush_rd", mem_rd, 1);
        chk("flush_addr", mem_addr, 20'h00010);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pfp = 16'h0020;
        for (int i = 0; i < 2; i++) begin
            chk("flush_hold", mem_rd, 1);
            tick();
        end
        chk("flush_hold", mem_rd, 1);
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_ready = 1'b0;
        chk("flush_no_push", push, 0);
        tick();
        chk("flush_idle", busy, 0);
        tmp = '{16'h0000, 16'h0020, 16'h4242, 0, 20'h00020, 2'b11, 16'h4242};
        run_fetch(tmp);

        // Flush arriving in the completing cycle also suppresses the push.
        pfp = 16'h0030; queue_full = 1'b0;
        tick();
        queue_full = 1'b1;
        mem_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mem_ready = 1'b0;
        chk("flush_ready_no_push", push, 0);
        tick();

        foreach (ev[i]) run_eu(ev[i]);

        // Reset during a wait-stated EU read.
        eu_req = 1'b1; eu_we = 1'b0; eu_wide = 1'b1; eu_addr = 20'h60000;
        tick();
        chk("rst_eu_rd", mem_rd, 1);
        tick();
        tick();
        reset = 1'b1;
        eu_req = 1'b0;
        tick();
        chk_zero("midreset");
        reset = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        mem_ready = 1'b0;
        chk("late_ready_no_ack", eu_ack, 0);
        chk("late_ready_busy", busy, 0);
        tick();
        chk("late_ready_no_ack2", eu_ack, 0);
        tick();

        chk("push_queue_empty", exp_push.size(), 0);
        chk("eu_queue_empty", exp_eu.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
